// File: rtl/cpu_defs.sv
// Shared fetch-queue entry definitions: one buffered instruction with its PC.
package cpu_defs;

    localparam int INST_W  = 32;
    localparam int PC_W    = 32;
    localparam int ENTRY_W = PC_W + INST_W;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_ram.sv
// Instruction-queue storage: two write ports at wr_ptr/wr_ptr+1, two async read ports.
// Latency: writes land on the clock edge, reads are combinational.
// Backpressure: none; the owner gates the write enables.
module ifq_ram
    import cpu_defs::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_1,
    input  logic               we_2,
    input  logic [PTR_W-1:0]   wr_ptr,
    input  logic [PTR_W-1:0]   rd_ptr,
    input  logic [ENTRY_W-1:0] wr_dat_1,
    input  logic [ENTRY_W-1:0] wr_dat_2,
    output logic [ENTRY_W-1:0] rd_dat_1,
    output logic [ENTRY_W-1:0] rd_dat_2
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_nx;
    logic [PTR_W-1:0]   rd_ptr_nx;

    // Pointer +1 wraps naturally because DEPTH is a power of two.
    assign wr_ptr_nx = wr_ptr + PTR_W'(1);
    assign rd_ptr_nx = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (we_1) mem_q[wr_ptr]    <= wr_dat_1;
        if (we_2) mem_q[wr_ptr_nx] <= wr_dat_2;
    end

    assign rd_dat_1 = mem_q[rd_ptr];
    assign rd_dat_2 = mem_q[rd_ptr_nx];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction FIFO between fetch return and decode, first-word fall-through.
// Latency: an entry written at edge N is presented on out_* from cycle N+1.
// Backpressure: in_ready drops when fewer than two entries are free; pushes while low are dropped.
module inst_fetch_queue
    import cpu_defs::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_valid_1,
    input  logic              in_valid_2,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst_1,
    input  logic [INST_W-1:0] in_inst_2,
    output logic              in_ready,
    output logic              out_valid_1,
    output logic              out_valid_2,
    output logic [PC_W-1:0]   out_pc_1,
    output logic [INST_W-1:0] out_inst_1,
    output logic [PC_W-1:0]   out_pc_2,
    output logic [INST_W-1:0] out_inst_2,
    input  logic [1:0]        pop_count,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C     = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] TWO_C     = (PTR_W+1)'(2);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W:0]   push_n, pop_req, pop_n;
    ifq_entry_t       wr_ent_1, wr_ent_2, rd_ent_1, rd_ent_2;

    // Ready looks only at registered occupancy; a pending pop does not re-open it.
    assign in_ready    = (count_q <= READY_MAX);
    assign out_valid_1 = (count_q >= ONE_C);
    assign out_valid_2 = (count_q >= TWO_C);
    assign count       = count_q;

    always_comb begin
        push_n = '0;
        if (in_valid && in_ready && !flush && in_valid_1)
            push_n = in_valid_2 ? TWO_C : ONE_C;
    end

    assign pop_req = (pop_count == 2'd3) ? TWO_C : (PTR_W+1)'(pop_count);
    assign pop_n   = (pop_req > count_q) ? count_q : pop_req;

    always_comb begin
        rd_ptr_d = rd_ptr_q + pop_n[PTR_W-1:0];
        wr_ptr_d = wr_ptr_q + push_n[PTR_W-1:0];
        count_d  = count_q + push_n - pop_n;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ent_1 = '{pc: in_pc,             inst: in_inst_1};
    assign wr_ent_2 = '{pc: in_pc + PC_W'(4),  inst: in_inst_2};

    ifq_ram #(.DEPTH(DEPTH)) u_ram (
        .clk      (clk),
        .we_1     (push_n != '0),
        .we_2     (push_n == TWO_C),
        .wr_ptr   (wr_ptr_q),
        .rd_ptr   (rd_ptr_q),
        .wr_dat_1 (wr_ent_1),
        .wr_dat_2 (wr_ent_2),
        .rd_dat_1 (rd_ent_1),
        .rd_dat_2 (rd_ent_2)
    );

    // RAM is never cleared, so stale words must be masked by the valids.
    assign out_pc_1   = out_valid_1 ? rd_ent_1.pc   : '0;
    assign out_inst_1 = out_valid_1 ? rd_ent_1.inst : '0;
    assign out_pc_2   = out_valid_2 ? rd_ent_2.pc   : '0;
    assign out_inst_2 = out_valid_2 ? rd_ent_2.inst : '0;

    overflow_chk: assert property (@(posedge clk) disable iff (rst || flush)
        (count_q + push_n - pop_n) <= DEPTH_C);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized scoreboard bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_valid_1, in_valid_2;
    logic [31:0] in_pc, in_inst_1, in_inst_2;
    logic        in_ready, out_valid_1, out_valid_2;
    logic [31:0] out_pc_1, out_inst_1, out_pc_2, out_inst_2;
    logic [1:0]  pop_count;
    logic [3:0]  count;

    ent_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   mon_sz, mon_p;
    logic [31:0] pcv;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_valid_1  (in_valid_1),
        .in_valid_2  (in_valid_2),
        .in_pc       (in_pc),
        .in_inst_1   (in_inst_1),
        .in_inst_2   (in_inst_2),
        .in_ready    (in_ready),
        .out_valid_1 (out_valid_1),
        .out_valid_2 (out_valid_2),
        .out_pc_1    (out_pc_1),
        .out_inst_1  (out_inst_1),
        .out_pc_2    (out_pc_2),
        .out_inst_2  (out_inst_2),
        .pop_count   (pop_count),
        .count       (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares the presented outputs with the scoreboard head, then retires
    // whatever the upcoming edge will consume (or everything on flush).
    always @(negedge clk) begin
        if (!rst) begin
            mon_sz = exp_q.size();
            chk("count", 32'(count), 32'(mon_sz));
            chk("in_ready", 32'(in_ready), 32'((DEPTH - mon_sz) >= 2));
            chk("out_valid_1", 32'(out_valid_1), 32'(mon_sz >= 1));
            chk("out_valid_2", 32'(out_valid_2), 32'(mon_sz >= 2));
            chk("out_pc_1",   out_pc_1,   (mon_sz >= 1) ? exp_q[0].pc   : 32'h0);
            chk("out_inst_1", out_inst_1, (mon_sz >= 1) ? exp_q[0].inst : 32'h0);
            chk("out_pc_2",   out_pc_2,   (mon_sz >= 2) ? exp_q[1].pc   : 32'h0);
            chk("out_inst_2", out_inst_2, (mon_sz >= 2) ? exp_q[1].inst : 32'h0);
            if (flush) begin
                exp_q.delete();
            end else begin
                mon_p = (pop_count == 2'd3) ? 2 : int'(pop_count);
                if (mon_p > mon_sz) mon_p = mon_sz;
                repeat (mon_p) void'(exp_q.pop_front());
            end
        end
    end

    // Driver: called at posedge+1, holds inputs through the next edge and records
    // the entries that edge is expected to accept.
    task automatic drive(input logic fl, input logic v, input logic v1, input logic v2,
                         input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                         input logic [1:0] pop);
        ent_t pend[$];
        flush = fl; in_valid = v; in_valid_1 = v1; in_valid_2 = v2;
        in_pc = pc; in_inst_1 = i1; in_inst_2 = i2; pop_count = pop;
        if (v && v1 && !fl && (DEPTH - exp_q.size()) >= 2) begin
            pend.push_back('{pc, i1});
            if (v2) pend.push_back('{pc + 32'd4, i2});
        end
        @(posedge clk);
        foreach (pend[k]) exp_q.push_back(pend[k]);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_valid_1 = 0; in_valid_2 = 0;
        in_pc = 0; in_inst_1 = 0; in_inst_2 = 0; pop_count = 0;
    endtask

    task automatic push_pair(input logic [1:0] pop);
        drive(0, 1, 1, 1, pcv, $urandom, $urandom, pop);
        pcv = pcv + 32'd8;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        pcv = 32'h0000_1000;
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // First pair, no pop
        drive(0, 1, 1, 1, 32'hBFC0_0000, 32'h2408_0001, 32'h2409_0002, 2'd0);
        chk("t2_count", 32'(count), 32'd2);
        chk("t2_pc_1", out_pc_1, 32'hBFC0_0000);
        chk("t2_pc_2", out_pc_2, 32'hBFC0_0004);
        chk("t2_inst_2", out_inst_2, 32'h2409_0002);

        // Asynchronous reset in the middle of a cycle
        idle();
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_valid_1", 32'(out_valid_1), 32'd0);
        chk("t1_valid_2", 32'(out_valid_2), 32'd0);
        chk("t1_ready", 32'(in_ready), 32'd1);
        chk("t1_pc_1", out_pc_1, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill to DEPTH-1; ready must drop and further pushes are dropped
        drive(0, 1, 1, 0, pcv, $urandom, $urandom, 2'd0);
        pcv = pcv + 32'd4;
        repeat (3) push_pair(2'd0);
        chk("t3_count", 32'(count), 32'd7);
        chk("t3_ready", 32'(in_ready), 32'd0);
        push_pair(2'd0);
        chk("t3_count_held", 32'(count), 32'd7);

        drive(1, 0, 0, 0, 0, 0, 0, 2'd0);
        chk("flush_count", 32'(count), 32'd0);

        // Steady push/pop across the pointer wrap
        repeat (3) push_pair(2'd0);
        repeat (3) push_pair(2'd2);
        for (int i = 0; i < 4; i++) begin
            push_pair(2'd2);
            chk("t4_count", 32'(count), 32'd6);
        end

        // Flush beats a same-cycle push and pop
        drive(1, 1, 1, 1, pcv, 32'hDEAD_0001, 32'hDEAD_0002, 2'd1);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid_1", 32'(out_valid_1), 32'd0);

        // Slot-2-only pushes nothing; over-pop clamps
        drive(0, 1, 0, 1, pcv, 32'h1111_1111, 32'h2222_2222, 2'd0);
        chk("t6_v2_only", 32'(count), 32'd0);
        drive(0, 1, 1, 0, pcv, 32'h3333_3333, 32'h4444_4444, 2'd2);
        chk("t6_push1_pop2", 32'(count), 32'd1);
        chk("t6_pc_1", out_pc_1, pcv);
        drive(0, 0, 0, 0, 0, 0, 0, 2'd3);
        chk("t6_pop3", 32'(count), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 2'd2);
        chk("t6_underflow", 32'(count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic fl, v, v1, v2;
            fl = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 5) != 0);
            v2 = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) pcv = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            drive(fl, v, v1, v2, pcv, $urandom, $urandom, 2'($urandom_range(0, 3)));
            pcv = pcv + 32'd8;
        end

        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
